// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one external (WIDTH+1)-bit adder between two
// requesters and returns each captured sum over a 4-phase req/ack handshake.
module adder_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   output logic             ack0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             ack1,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   input  logic [WIDTH:0]   add_sum,
   output logic [WIDTH:0]   result,
   output logic             result_id,
   output logic             result_valid,
   output logic             busy,
   output logic [WIDTH:0]   led,
   output logic [1:0]       dbg_state
);

   // Handshake: reqN is a level held (operands stable) until ackN is seen;
   // ackN rises together with result_valid and falls on the edge after reqN is low.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXEC    = 2'd1,
      CAPTURE = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t state;
   logic   grant;
   logic   last_grant;
   logic   pick;
   logic   grant_req;

   // Under contention the requester that was not served last wins.
   always_comb begin
      pick      = (req0 && req1) ? ~last_grant : req1;
      grant_req = grant ? req1 : req0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         ack0         <= 1'b0;
         ack1         <= 1'b0;
         result_valid <= 1'b0;
         add_a        <= '0;
         add_b        <= '0;
         result       <= '0;
         led          <= '0;
         result_id    <= 1'b0;
         grant        <= 1'b0;
         last_grant   <= 1'b1;
      end else begin
         result_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  add_a      <= pick ? a1 : a0;
                  add_b      <= pick ? b1 : b0;
                  grant      <= pick;
                  last_grant <= pick;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               result       <= add_sum;
               led          <= add_sum;
               result_id    <= grant;
               result_valid <= 1'b1;
               if (grant) ack1 <= 1'b1;
               else       ack0 <= 1'b1;
               state        <= RELEASE;
            end
            RELEASE: begin
               if (!grant_req) begin
                  ack0  <= 1'b0;
                  ack1  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule
